// File: rtl/key_debounce_toggle_pkg.sv
// rtl/key_debounce_toggle_pkg.sv - shared state encoding and helpers for the key debouncer
package key_debounce_toggle_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED    = 2'b00,
      ST_DEB_PRESS   = 2'b01,
      ST_PRESSED     = 2'b10,
      ST_DEB_RELEASE = 2'b11
   } deb_state_t;

   // Raw key level seen when the button is not pressed.
   function automatic logic released_raw_level(input logic active_low);
      return active_low;
   endfunction

   // Converts a synchronised raw sample into 1 = pressed.
   function automatic logic pressed_level(input logic raw, input logic active_low);
      return raw ^ active_low;
   endfunction

endpackage

// File: rtl/key_debounce_toggle_sync_2ff.sv
// rtl/key_debounce_toggle_sync_2ff.sv - generic two-flop synchroniser with configurable reset value
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_resetn,
   input  logic i_d,
   output logic o_q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_s1 <= RESET_VAL;
         r_s2 <= RESET_VAL;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/key_debounce_toggle.sv
// rtl/key_debounce_toggle.sv - push-button synchroniser, timed debouncer and direction toggle
module key_debounce_toggle
   import key_debounce_toggle_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 100000,
   parameter int   CNT_W           = 17,
   parameter logic KEY_ACTIVE_LOW  = 1'b1,
   parameter logic TOGGLE_INIT     = 1'b1
) (
   input  logic clock_5,
   input  logic reset,
   input  logic key_in,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic up_down,
   output logic busy
);

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic       w_key_sync;
   logic       w_pressed;
   deb_state_t r_state;
   logic [CNT_W-1:0] r_cnt;
   logic       r_level;
   logic       r_press;
   logic       r_release;
   logic       r_up_down;
   logic       r_busy;

   sync_2ff #(
      .RESET_VAL (released_raw_level(KEY_ACTIVE_LOW))
   ) u_sync (
      .i_clk    (clock_5),
      .i_resetn (reset),
      .i_d      (key_in),
      .o_q      (w_key_sync)
   );

   assign w_pressed = pressed_level(w_key_sync, KEY_ACTIVE_LOW);

   // Outputs are updated together with the state so they always reflect the registered state.
   always_ff @(posedge clock_5) begin
      if (!reset) begin
         r_state   <= ST_RELEASED;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_up_down <= TOGGLE_INIT;
         r_busy    <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         case (r_state)
            ST_RELEASED: begin
               r_cnt <= '0;
               if (w_pressed) begin
                  r_state <= ST_DEB_PRESS;
                  r_busy  <= 1'b1;
               end
            end
            ST_DEB_PRESS: begin
               if (!w_pressed) begin
                  r_state <= ST_RELEASED;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else if (r_cnt == C_CNT_LAST) begin
                  r_state   <= ST_PRESSED;
                  r_cnt     <= '0;
                  r_busy    <= 1'b0;
                  r_level   <= 1'b1;
                  r_press   <= 1'b1;
                  r_up_down <= ~r_up_down;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_PRESSED: begin
               r_cnt <= '0;
               if (!w_pressed) begin
                  r_state <= ST_DEB_RELEASE;
                  r_busy  <= 1'b1;
               end
            end
            ST_DEB_RELEASE: begin
               if (w_pressed) begin
                  r_state <= ST_PRESSED;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else if (r_cnt == C_CNT_LAST) begin
                  r_state   <= ST_RELEASED;
                  r_cnt     <= '0;
                  r_busy    <= 1'b0;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_RELEASED;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
               r_level <= 1'b0;
            end
         endcase
      end
   end

   assign key_level   = r_level;
   assign key_press   = r_press;
   assign key_release = r_release;
   assign up_down     = r_up_down;
   assign busy        = r_busy;

endmodule

// File: tb/tb_key_debounce_toggle.sv
// tb/tb_key_debounce_toggle.sv - table-driven self-checking bench for key_debounce_toggle
module tb_key_debounce_toggle;

   localparam int D = 8;

   logic clock_5 = 1'b0;
   logic reset   = 1'b0;
   logic key_in  = 1'b1;
   logic key_level, key_press, key_release, up_down, busy;

   key_debounce_toggle #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (4),
      .KEY_ACTIVE_LOW  (1'b1),
      .TOGGLE_INIT     (1'b1)
   ) dut (
      .clock_5     (clock_5),
      .reset       (reset),
      .key_in      (key_in),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .up_down     (up_down),
      .busy        (busy)
   );

   always #5 clock_5 = ~clock_5;

   // exp = {key_level, key_press, key_release, up_down, busy}
   typedef struct {
      logic       rst_n;
      logic       key;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic add(input int n, input logic rst_n, input logic key, input logic [4:0] exp);
      vec_t v;
      v.rst_n = rst_n;
      v.key   = key;
      v.exp   = exp;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   task automatic step(input logic rst_n, input logic key);
      @(negedge clock_5);
      reset  = rst_n;
      key_in = key;
      @(posedge clock_5);
      #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic pulse_run(input int len, input int exp_presses);
      int pr, rl, both;
      pr = 0; rl = 0; both = 0;
      for (int i = 0; i < len + 20; i++) begin
         step(1'b1, (i < len) ? 1'b0 : 1'b1);
         pr   += int'(key_press);
         rl   += int'(key_release);
         both += int'(key_press & key_release);
      end
      check($sformatf("glitch%0d_presses", len), pr, exp_presses);
      check($sformatf("glitch%0d_releases", len), rl, exp_presses);
      check($sformatf("glitch%0d_overlap", len), both, 0);
      check($sformatf("glitch%0d_busy_idle", len), int'(busy), 0);
   endtask

   initial begin
      int lat;

      // Reset and idle
      add(3,  1'b0, 1'b1, 5'b00010);
      add(20, 1'b1, 1'b1, 5'b00010);
      // Clean press
      add(2,  1'b1, 1'b0, 5'b00010);
      add(8,  1'b1, 1'b0, 5'b00011);
      add(1,  1'b1, 1'b0, 5'b11000);
      add(3,  1'b1, 1'b0, 5'b10000);
      // Release
      add(2,  1'b1, 1'b1, 5'b10000);
      add(8,  1'b1, 1'b1, 5'b10001);
      add(1,  1'b1, 1'b1, 5'b00100);
      add(3,  1'b1, 1'b1, 5'b00000);
      // Bounce: low 5, high 2, low 4, then high
      add(2,  1'b1, 1'b0, 5'b00000);
      add(3,  1'b1, 1'b0, 5'b00001);
      add(2,  1'b1, 1'b1, 5'b00001);
      add(2,  1'b1, 1'b0, 5'b00000);
      add(2,  1'b1, 1'b0, 5'b00001);
      add(2,  1'b1, 1'b1, 5'b00001);
      add(5,  1'b1, 1'b1, 5'b00000);
      // Reset at counter=5 in DEB_PRESS, key kept low: debounce restarts
      add(2,  1'b1, 1'b0, 5'b00000);
      add(6,  1'b1, 1'b0, 5'b00001);
      add(2,  1'b0, 1'b0, 5'b00010);
      add(2,  1'b1, 1'b0, 5'b00010);
      add(8,  1'b1, 1'b0, 5'b00011);
      add(1,  1'b1, 1'b0, 5'b11000);
      add(2,  1'b1, 1'b0, 5'b10000);
      add(2,  1'b1, 1'b1, 5'b10000);
      add(8,  1'b1, 1'b1, 5'b10001);
      add(1,  1'b1, 1'b1, 5'b00100);
      add(2,  1'b1, 1'b1, 5'b00000);
      // Second full press back to up, then long hold: no auto-repeat
      add(2,  1'b1, 1'b0, 5'b00000);
      add(8,  1'b1, 1'b0, 5'b00001);
      add(1,  1'b1, 1'b0, 5'b11010);
      add(1000, 1'b1, 1'b0, 5'b10010);
      add(2,  1'b1, 1'b1, 5'b10010);
      add(8,  1'b1, 1'b1, 5'b10011);
      add(1,  1'b1, 1'b1, 5'b00110);
      add(2,  1'b1, 1'b1, 5'b00010);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst_n, tbl[i].key);
         check($sformatf("vec%0d", i),
               int'({key_level, key_press, key_release, up_down, busy}),
               int'(tbl[i].exp));
      end

      // Press latency measured from the first sampling edge
      step(1'b1, 1'b0);
      lat = 0;
      while (!key_press && lat < 50) begin
         step(1'b1, 1'b0);
         lat++;
      end
      check("press_latency", lat, D + 2);
      step(1'b1, 1'b0);
      check("press_one_cycle", int'(key_press), 0);
      check("press_up_down", int'(up_down), 0);

      step(1'b1, 1'b1);
      lat = 0;
      while (!key_release && lat < 50) begin
         step(1'b1, 1'b1);
         lat++;
      end
      check("release_latency", lat, D + 2);
      step(1'b1, 1'b1);
      check("release_one_cycle", int'(key_release), 0);
      check("release_level", int'(key_level), 0);

      // D-1 synchronised cycles rejected; D+1 accepted
      pulse_run(D - 1, 0);
      check("after_glitch_up_down", int'(up_down), 0);
      pulse_run(D + 1, 1);
      check("after_long_up_down", int'(up_down), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
